// File: rtl/uart_loopback_tester.sv
// uart_loopback_tester: stop-and-wait UART echo checker with its own 8N1
// serializer and receiver. Sends (SEED + i) mod 256 for i = 0..N-1, waits
// for each echo, counts mismatches/framing errors and flags a missing echo.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// SEND   | serializing the current byte, start bit through stop bit
// WAIT   | stop bit done, waiting for the echo or the timeout
// CHECK  | compare echo with the byte sent, advance or finish
// FINISH | one-cycle done pulse, then back to IDLE
module uart_loopback_tester #(
  parameter int         SYSTEM_CLOCK = 32000000,
  parameter int         BAUD_RATE    = 9600,
  parameter logic [7:0] SEED         = 8'h00,
  parameter int         TIMEOUT_BITS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] num_bytes,
  input  logic       rx,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       timeout
);

  localparam int CPB    = SYSTEM_CLOCK / BAUD_RATE;
  localparam int TO_CYC = TIMEOUT_BITS * CPB;
  localparam int BW     = $clog2(CPB + 1);
  localparam int TW     = $clog2(TO_CYC + 1);

  localparam logic [BW-1:0] BIT_LOAD  = BW'(CPB - 1);
  localparam logic [BW-1:0] HALF_LOAD = BW'(CPB / 2 - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TO_CYC - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEND   = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  logic [2:0]    state;
  logic [9:0]    tx_sh;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] bit_tmr;
  logic [TW-1:0] to_tmr;
  logic [7:0]    cur_byte;
  logic [7:0]    idx;
  logic [7:0]    last_idx;
  logic          mismatch;

  logic          rx_s1, rx_s2, rx_s3;
  logic          r_on;
  logic [3:0]    r_cnt;
  logic [BW-1:0] r_tmr;
  logic [7:0]    r_sh;
  logic [7:0]    r_data;
  logic          r_ferr;
  logic          r_valid;

  assign busy     = (state == ST_SEND) || (state == ST_WAIT) || (state == ST_CHECK);
  assign done     = (state == ST_FINISH);
  assign mismatch = (r_data != cur_byte) || r_ferr;

  // Main sequencer: serializer, echo timeout and result bookkeeping.
  // last_idx = num_bytes - 1 in 8 bits, so num_bytes = 0 naturally means 256.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx        <= 1'b1;
      tx_sh     <= '1;
      bit_cnt   <= '0;
      bit_tmr   <= '0;
      to_tmr    <= '0;
      cur_byte  <= '0;
      idx       <= '0;
      last_idx  <= '0;
      pass      <= 1'b0;
      err_count <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SEND;
            err_count <= '0;
            timeout   <= 1'b0;
            pass      <= 1'b0;
            last_idx  <= num_bytes - 8'd1;
            idx       <= '0;
            cur_byte  <= SEED;
            tx_sh     <= {1'b1, SEED, 1'b0};
            bit_cnt   <= 4'd10;
            bit_tmr   <= '0;
          end
        end
        ST_SEND: begin
          if (bit_tmr == '0) begin
            if (bit_cnt == '0) begin
              state  <= ST_WAIT;
              to_tmr <= TO_LOAD;
            end else begin
              tx      <= tx_sh[0];
              tx_sh   <= {1'b1, tx_sh[9:1]};
              bit_cnt <= bit_cnt - 4'd1;
              bit_tmr <= BIT_LOAD;
            end
          end else begin
            bit_tmr <= bit_tmr - 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_valid) begin
            state <= ST_CHECK;
          end else if (to_tmr == '0) begin
            timeout <= 1'b1;
            state   <= ST_FINISH;
          end else begin
            to_tmr <= to_tmr - 1'b1;
          end
        end
        ST_CHECK: begin
          if (mismatch && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
          if (idx == last_idx) begin
            state <= ST_FINISH;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            state    <= ST_SEND;
            idx      <= idx + 8'd1;
            cur_byte <= cur_byte + 8'd1;
            tx_sh    <= {1'b1, cur_byte + 8'd1, 1'b0};
            bit_cnt  <= 4'd10;
            bit_tmr  <= '0;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Free-running receiver: synchronize, detect start, sample at bit centres.
  // r_cnt: 0 = start-bit check, 1..8 = data bits, 9 = stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_s3   <= 1'b1;
      r_on    <= 1'b0;
      r_cnt   <= '0;
      r_tmr   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_ferr  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_s3   <= rx_s2;
      r_valid <= 1'b0;
      if (!r_on) begin
        if (rx_s3 && !rx_s2) begin
          r_on  <= 1'b1;
          r_cnt <= '0;
          r_tmr <= HALF_LOAD;
        end
      end else if (r_tmr != '0) begin
        r_tmr <= r_tmr - 1'b1;
      end else if (r_cnt == '0) begin
        if (rx_s2) begin
          r_on <= 1'b0;
        end else begin
          r_cnt <= 4'd1;
          r_tmr <= BIT_LOAD;
        end
      end else if (r_cnt <= 4'd8) begin
        r_sh  <= {rx_s2, r_sh[7:1]};
        r_cnt <= r_cnt + 4'd1;
        r_tmr <= BIT_LOAD;
      end else begin
        r_data  <= r_sh;
        r_ferr  <= !rx_s2;
        r_valid <= 1'b1;
        r_on    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_loopback_tester.sv
// Bench for uart_loopback_tester: loopback, corrupting echo, silent line,
// glitches, back-to-back runs and asynchronous reset.
module tb_uart_loopback_tester;

  localparam int         SYS  = 800;
  localparam int         BAUD = 100;
  localparam int         CPB  = SYS / BAUD;
  localparam logic [7:0] SEED = 8'hFE;
  localparam int         TOB  = 30;
  // loopback path latency; a zero-latency tie would return the stop-bit
  // centre while the tester is still inside its own stop bit
  localparam int         LAT  = CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_bytes = 8'd0;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic       rx;
  logic       tx, busy, done, pass, timeout;
  logic [7:0] err_count;
  logic [15:0] dl = '1;

  uart_loopback_tester #(
    .SYSTEM_CLOCK(SYS), .BAUD_RATE(BAUD), .SEED(SEED), .TIMEOUT_BITS(TOB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_bytes(num_bytes), .rx(rx),
    .tx(tx), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dl <= {dl[14:0], tx};
  assign rx = loop ? dl[LAT-1] : rx_drv;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int done_cnt = 0;
  int last_done_cyc = 0;
  always @(negedge clk) if (done) begin done_cnt++; last_done_cyc = cyc; end

  // passive decoder of every frame on tx
  logic [7:0] sent_q[$];
  int         sstart_q[$];
  initial begin
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge tx);
      t0 = cyc;
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (tx == 1'b0) begin
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(posedge clk);
          #1;
          b[j] = tx;
        end
        repeat (CPB) @(posedge clk);
        sent_q.push_back(b);
        sstart_q.push_back(t0);
      end
    end
  end

  int total = 0;
  int passed = 0;
  int fails = 0;
  bit flip_a[256];
  bit stop_a[256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] n);
    @(negedge clk);
    num_bytes = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    num_bytes = 8'($urandom);
  endtask

  task automatic wait_done(input string tag, input int budget, input int d0);
    int i;
    for (i = 0; i < budget && done_cnt <= d0; i++) @(negedge clk);
    chk({tag, "_done_in_time"}, done_cnt > d0, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  // reference: byte i = (SEED + i) mod 256; pass iff no errors and no timeout
  task automatic check_run(input string tag, input int n_sent, input int n_err, input bit to);
    int bad = 0;
    int e = (n_err > 255) ? 255 : n_err;
    for (int i = 0; i < sent_q.size(); i++)
      if (sent_q[i] !== 8'((int'(SEED) + i) % 256)) bad++;
    chk({tag, "_frames"}, sent_q.size(), n_sent);
    chk({tag, "_seq_bad"}, bad, 0);
    chk({tag, "_err_count"}, err_count, e);
    chk({tag, "_timeout"}, timeout, to);
    chk({tag, "_pass"}, pass, (e == 0) && !to);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic send_echo(input logic [7:0] b, input logic stopv);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      rx_drv = b[j];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stopv;
    repeat (CPB) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic echo_run(input string tag, input int n, input bit glitch);
    int exp_err = 0;
    int d0;
    int w;
    loop = 1'b0;
    rx_drv = 1'b1;
    sent_q.delete();
    sstart_q.delete();
    d0 = done_cnt;
    do_start(8'(n));
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (sent_q.size() <= k && w < 40 * CPB) begin @(negedge clk); w++; end
      if (sent_q.size() <= k) break;
      if (glitch) begin
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (CPB) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, CPB)) @(negedge clk);
      end
      send_echo(sent_q[k] ^ {7'd0, flip_a[k]}, !stop_a[k]);
      if (flip_a[k] || stop_a[k]) exp_err++;
    end
    wait_done(tag, 40 * CPB, d0);
    check_run(tag, n, exp_err, 1'b0);
  endtask

  initial begin
    int d0;
    int n;
    int i;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // loopback, 4 bytes, extra start while busy
    loop = 1'b1;
    sent_q.delete();
    sstart_q.delete();
    d0 = done_cnt;
    do_start(8'd4);
    chk("start_busy", busy, 1);
    @(negedge clk);
    chk("start_bit", tx, 0);
    repeat (60) @(negedge clk);
    start = 1'b1;
    num_bytes = 8'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done("loop4", 4 * 26 * CPB, d0);
    check_run("loop4", 4, 0, 1'b0);
    chk("loop4_byte2", sent_q[2], 8'h00);

    // back-to-back: run of 2, then start held across FINISH into IDLE
    sent_q.delete();
    sstart_q.delete();
    do_start(8'd2);
    for (i = 0; i < 2 * 26 * CPB && !done; i++) @(negedge clk);
    chk("b2b_first_done", done, 1);
    chk("b2b_first_pass", pass, 1);
    chk("b2b_first_frames", sent_q.size(), 2);
    start = 1'b1;
    num_bytes = 8'd3;
    @(negedge clk);
    d0 = done_cnt;
    chk("b2b_idle_gap", busy, 0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accepted", busy, 1);
    sent_q.delete();
    sstart_q.delete();
    wait_done("b2b", 3 * 26 * CPB, d0);
    check_run("b2b", 3, 0, 1'b0);

    // 256-byte loopback, wraps FE,FF,00,01,...
    sent_q.delete();
    sstart_q.delete();
    d0 = done_cnt;
    do_start(8'd0);
    wait_done("wrap256", 256 * 26 * CPB, d0);
    check_run("wrap256", 256, 0, 1'b0);
    chk("wrap256_b1", sent_q[1], 8'hFF);
    chk("wrap256_b3", sent_q[3], 8'h01);

    // corrupting echo: bit 0 flipped on bytes 1,2 and stop bit low on byte 4
    for (int k = 0; k < 256; k++) begin flip_a[k] = 1'b0; stop_a[k] = 1'b0; end
    flip_a[1] = 1'b1;
    flip_a[2] = 1'b1;
    stop_a[4] = 1'b1;
    echo_run("corrupt5", 5, 1'b0);

    // random corruption patterns
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < 256; k++) begin
        flip_a[k] = ($urandom_range(0, 3) == 0);
        stop_a[k] = ($urandom_range(0, 4) == 0);
      end
      echo_run($sformatf("rand%0d", r), n, 1'b0);
    end

    // short glitches before each clean echo
    for (int k = 0; k < 256; k++) begin flip_a[k] = 1'b0; stop_a[k] = 1'b0; end
    echo_run("glitch", 2, 1'b1);

    // silent line: one frame, then timeout 30 bit periods after its stop bit
    loop = 1'b0;
    rx_drv = 1'b1;
    sent_q.delete();
    sstart_q.delete();
    d0 = done_cnt;
    do_start(8'd3);
    wait_done("silent", 60 * CPB, d0);
    check_run("silent", 1, 0, 1'b1);
    if (sstart_q.size() > 0) begin
      n = last_done_cyc - sstart_q[0];
      chk("silent_done_delay_window", (n >= 40 * CPB) && (n <= 40 * CPB + 2), 1);
    end
    repeat (20) @(negedge clk);
    chk("silent_timeout_held", timeout, 1);

    // asynchronous reset during the start bit
    loop = 1'b1;
    do_start(8'd5);
    @(negedge clk);
    chk("rst_mid_pre_tx", tx, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_pass", pass, 0);
    chk("rst_mid_err", err_count, 0);
    chk("rst_mid_timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_after_busy", busy, 0);
    chk("rst_after_tx", tx, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
